// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM speed controller.
// Holds the controller FSM encoding and the speed range helpers.
package pwm_ctrl_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ctrl_state_t;

    // One slew step from cur toward goal; callers only use it when cur != goal.
    function automatic logic [SPEED_W-1:0] step_toward(
        input logic [SPEED_W-1:0] cur,
        input logic [SPEED_W-1:0] goal
    );
        if (cur > goal)
            return cur - SPEED_W'(1);
        else
            return cur + SPEED_W'(1);
    endfunction

endpackage

// File: rtl/pwm_speed_ctrl_btn_debounce.sv
// Button front end: 2-FF synchronizer, counting debouncer and rising-edge press pulse.
// Buttons already held when reset releases cannot fire until seen released once.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             armed;
    logic [1:0]       fill;
    logic [CNT_W-1:0] cnt;

    // fill marks when the synchronizer holds real samples, so armed only
    // sets on a genuine released level rather than on the reset zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            armed  <= 1'b0;
            fill   <= 2'b00;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            press <= 1'b0;

            if (fill[1] && !sync2)
                armed <= 1'b1;

            if (sync2 != stable) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                    stable <= sync2;
                    cnt    <= '0;
                    press  <= sync2 & armed;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_speed_ctrl.sv
// Upstream control for the PWM width generator: debounced buttons set a target
// speed, and a slew-limited ramp drives the generator with soft stopping.
module pwm_speed_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RAMP_CYCLES     = 100000,
    parameter int CNT_W           = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_run,
    output logic               enable_out,
    output logic [SPEED_W-1:0] speed_out,
    output logic [SPEED_W-1:0] target,
    output logic               busy
);

    logic               up_press;
    logic               down_press;
    logic               run_press;
    ctrl_state_t        state;
    logic [SPEED_W-1:0] goal;
    logic [CNT_W-1:0]   ramp_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_up (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_up),
        .press (up_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_down (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_down),
        .press (down_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_run (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .press (run_press)
    );

    // Only RUN chases the user's target; both other states wind speed down to 0.
    always_comb begin
        goal = '0;
        if (state == RUN)
            goal = target;
    end

    assign busy = (speed_out != goal);

    // Simultaneous up and down presses cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
        end else if (up_press && !down_press) begin
            if (target != SPEED_MAX)
                target <= target + SPEED_W'(1);
        end else if (down_press && !up_press) begin
            if (target != '0)
                target <= target - SPEED_W'(1);
        end
    end

    // A run press in STOPPING takes priority over the exit to OFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= OFF;
            enable_out <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (run_press) begin
                        state      <= RUN;
                        enable_out <= 1'b1;
                    end
                end
                RUN: begin
                    if (run_press)
                        state <= STOPPING;
                end
                STOPPING: begin
                    if (run_press) begin
                        state <= RUN;
                    end else if (speed_out == '0) begin
                        state      <= OFF;
                        enable_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= OFF;
                    enable_out <= 1'b0;
                end
            endcase
        end
    end

    // The interval counter keeps running across goal changes, so a reversal
    // only shows up at the next scheduled step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_out <= '0;
            ramp_cnt  <= '0;
        end else if (speed_out != goal) begin
            if (ramp_cnt == CNT_W'(RAMP_CYCLES - 1)) begin
                speed_out <= step_toward(speed_out, goal);
                ramp_cnt  <= '0;
            end else begin
                ramp_cnt <= ramp_cnt + CNT_W'(1);
            end
        end else begin
            ramp_cnt <= '0;
        end
    end

endmodule
